mem_stage_pipe: RTL and testbench

- Parametrised, registered memory stage for the Y86-64 pipeline. Sits between the M and W pipeline registers.
- Performs the data-memory access selected by icode, with a configurable multi-cycle access latency.
- Stalls upstream while an access is in flight. Owns the M/W pipeline register.
- Flags ADR on out-of-range addresses and suppresses memory writes after any exception.

---
 rtl/mem_stage_pipe.sv | 143 ++++++++++++++
 tb/tb_mem_stage_pipe.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage_pipe.sv
// mem_stage_pipe: Y86-64 memory stage with multi-cycle data access and M/W register; define MEM_BYTE_ADDR_EN for byte addressing
module mem_stage_pipe #(
    parameter int DATA_W  = 64,
    parameter int ADDR_W  = 11,
    parameter int MEM_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              M_valid,
    input  logic [3:0]        M_stat,
    input  logic [3:0]        M_icode,
    input  logic              M_cnd,
    input  logic [DATA_W-1:0] M_valE,
    input  logic [DATA_W-1:0] M_valA,
    input  logic [3:0]        M_dstE,
    input  logic [3:0]        M_dstM,
    input  logic              W_stall,
    input  logic              W_bubble,
    output logic              m_stall,
    output logic              W_valid,
    output logic [3:0]        W_stat,
    output logic [3:0]        W_icode,
    output logic              W_cnd,
    output logic [DATA_W-1:0] W_valE,
    output logic [DATA_W-1:0] W_valM,
    output logic [3:0]        W_dstE,
    output logic [3:0]        W_dstM,
    output logic              halted
);
    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [DATA_W-1:0] DEPTH_W = DATA_W'(DEPTH);
    localparam logic [3:0] AOK = 4'b0001;
    localparam logic [3:0] ADR = 4'b1000;
    typedef enum logic {IDLE, BUSY} state_t;
    state_t state, state_n;
    logic [3:0] cnt, cnt_n;
    logic [DATA_W-1:0] mem [DEPTH];
    logic              l_valid, l_cnd;
    logic [3:0]        l_stat, l_icode, l_dstE, l_dstM;
    logic [DATA_W-1:0] l_valE, l_valA;
    logic              s_valid, s_cnd;
    logic [3:0]        s_stat, s_icode, s_dstE, s_dstM;
    logic [DATA_W-1:0] s_valE, s_valA, addr, c_valM;
    logic [ADDR_W-1:0] idx;
    logic              is_wr, is_rd, mem_op, in_rng, load_w, bubble, latch, do_wr;
    logic [3:0]        c_stat;
    // In BUSY the access completes from the latched copy, not from the live M inputs
    wire busy = state == BUSY;
    assign s_valid = busy ? l_valid : M_valid;
    assign s_stat  = busy ? l_stat  : M_stat;
    assign s_icode = busy ? l_icode : M_icode;
    assign s_cnd   = busy ? l_cnd   : M_cnd;
    assign s_valE  = busy ? l_valE  : M_valE;
    assign s_valA  = busy ? l_valA  : M_valA;
    assign s_dstE  = busy ? l_dstE  : M_dstE;
    assign s_dstM  = busy ? l_dstM  : M_dstM;
    assign is_wr  = s_icode == 4'h4 || s_icode == 4'h8 || s_icode == 4'hA;
    assign is_rd  = s_icode == 4'h5 || s_icode == 4'h9 || s_icode == 4'hB;
    assign addr   = (s_icode == 4'h9 || s_icode == 4'hB) ? s_valA : s_valE;
    assign mem_op = s_valid && s_stat == AOK && (is_wr || is_rd);
`ifdef MEM_BYTE_ADDR_EN
    assign in_rng = (addr >> 3) < DEPTH_W && addr[2:0] == 3'd0;
    assign idx    = addr[ADDR_W+2:3];
`else
    assign in_rng = addr < DEPTH_W;
    assign idx    = addr[ADDR_W-1:0];
`endif
    assign c_stat = (mem_op && !in_rng) ? ADR : s_stat;
    assign c_valM = (mem_op && is_rd && in_rng) ? mem[idx] : '0;
    assign do_wr  = !rst && load_w && mem_op && is_wr && in_rng && !halted;
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        m_stall = 1'b0;
        load_w  = 1'b0;
        bubble  = 1'b0;
        latch   = 1'b0;
        if (state == IDLE) begin
            if (W_stall) m_stall = 1'b1;
            else if (W_bubble) bubble = 1'b1;
            else if (mem_op && MEM_LAT > 1) begin
                latch   = 1'b1;
                cnt_n   = 4'(MEM_LAT - 1);
                state_n = BUSY;
                m_stall = 1'b1;
            end else load_w = 1'b1;
        end else begin
            m_stall = W_stall || cnt > 4'd1;
            if (!W_stall) begin
                cnt_n   = cnt == 4'd1 ? 4'd0 : cnt - 4'd1;
                load_w  = cnt == 4'd1;
                state_n = cnt == 4'd1 ? IDLE : BUSY;
            end
        end
    end
    always_ff @(posedge clk) begin
        if (do_wr) mem[idx] <= s_valA;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= 4'd0;
            halted <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            if (load_w && s_valid && c_stat != AOK) halted <= 1'b1;
        end
    end
    always_ff @(posedge clk) begin
        if (!rst && latch) begin
            l_valid <= M_valid;
            l_stat  <= M_stat;
            l_icode <= M_icode;
            l_cnd   <= M_cnd;
            l_valE  <= M_valE;
            l_valA  <= M_valA;
            l_dstE  <= M_dstE;
            l_dstM  <= M_dstM;
        end
    end
    always_ff @(posedge clk) begin
        if (rst || bubble) begin
            W_valid <= 1'b0;
            W_stat  <= AOK;
            W_icode <= 4'h1;
            W_cnd   <= 1'b0;
            W_valE  <= '0;
            W_valM  <= '0;
            W_dstE  <= 4'hF;
            W_dstM  <= 4'hF;
        end else if (load_w) begin
            W_valid <= s_valid;
            W_stat  <= c_stat;
            W_icode <= s_icode;
            W_cnd   <= s_cnd;
            W_valE  <= s_valE;
            W_valM  <= c_valM;
            W_dstE  <= s_dstE;
            W_dstM  <= s_dstM;
        end
    end
endmodule

// File: tb/tb_mem_stage_pipe.sv
// tb_mem_stage_pipe: directed checks of mem_stage_pipe at latencies 1, 3, 4 and 2 sharing one stimulus bus
module tb_mem_stage_pipe;
`ifdef MEM_BYTE_ADDR_EN
    localparam int SC = 8;
    localparam logic [3:0] EXP13 = 4'b1000;
`else
    localparam int SC = 1;
    localparam logic [3:0] EXP13 = 4'b0001;
`endif
    logic        clk = 1'b0;
    logic        rst, M_valid, M_cnd, W_stall, W_bubble;
    logic [3:0]  M_stat, M_icode, M_dstE, M_dstM;
    logic [63:0] M_valE, M_valA;
    logic        ms [4], wv [4], wc [4], hl [4];
    logic [3:0]  ws [4], wi [4], wde [4], wdm [4];
    logic [63:0] we [4], wm [4];
    int checks = 0;
    int errors = 0;
    always #5 clk = ~clk;
    for (genvar g = 0; g < 4; g++) begin : g_dut
        mem_stage_pipe #(.DATA_W(64), .ADDR_W(11), .MEM_LAT(g == 0 ? 1 : g == 1 ? 3 : g == 2 ? 4 : 2)) u_dut (
            .clk(clk), .rst(rst), .M_valid(M_valid), .M_stat(M_stat), .M_icode(M_icode),
            .M_cnd(M_cnd), .M_valE(M_valE), .M_valA(M_valA), .M_dstE(M_dstE), .M_dstM(M_dstM),
            .W_stall(W_stall), .W_bubble(W_bubble), .m_stall(ms[g]), .W_valid(wv[g]),
            .W_stat(ws[g]), .W_icode(wi[g]), .W_cnd(wc[g]), .W_valE(we[g]), .W_valM(wm[g]),
            .W_dstE(wde[g]), .W_dstM(wdm[g]), .halted(hl[g])
        );
    end
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask
    task automatic tick;
        @(posedge clk);
        #1;
    endtask
    task automatic drive(input logic [3:0] ic, input logic [63:0] ve, input logic [63:0] va);
        M_valid = 1'b1;
        M_stat  = 4'b0001;
        M_icode = ic;
        M_cnd   = 1'b1;
        M_valE  = ve;
        M_valA  = va;
        M_dstE  = 4'h2;
        M_dstM  = 4'h3;
    endtask
    task automatic idle;
        drive(4'h1, 64'd0, 64'd0);
        M_valid = 1'b0;
    endtask
    task automatic reset_all;
        rst = 1'b1;
        W_stall = 1'b0;
        W_bubble = 1'b0;
        idle();
        tick();
        rst = 1'b0;
    endtask
    task automatic do_op(input int k, input logic [3:0] ic, input logic [63:0] ve, input logic [63:0] va);
        int n = 0;
        drive(ic, ve, va);
        #1;
        while (ms[k] && n < 20) begin
            tick();
            n++;
        end
        chk("op_timeout", 64'(n < 20), 64'd1);
        tick();
        idle();
    endtask
    initial begin
        reset_all();
        chk("rst_valid", wv[0], 0);
        chk("rst_stat", ws[0], 1);
        chk("rst_icode", wi[0], 1);
        chk("rst_cnd", wc[0], 0);
        chk("rst_valE", we[0], 0);
        chk("rst_valM", wm[0], 0);
        chk("rst_dstE", wde[0], 15);
        chk("rst_dstM", wdm[0], 15);
        chk("rst_halted", hl[0], 0);
        drive(4'h3, 64'h55, 64'd0);
        #1 chk("irmov_stall", ms[0], 0);
        tick();
        chk("irmov_valE", we[0], 64'h55);
        chk("irmov_stat", ws[0], 1);
        chk("irmov_valid", wv[0], 1);
        chk("irmov_icode", wi[0], 3);
        chk("irmov_dstE", wde[0], 2);
        chk("irmov_cnd", wc[0], 1);
        drive(4'h4, 64'(10 * SC), 64'hDEAD);
        #1 chk("rmmov_stall", ms[0], 0);
        tick();
        chk("rmmov_valM", wm[0], 0);
        drive(4'h5, 64'(10 * SC), 64'd0);
        tick();
        chk("mrmov_valM", wm[0], 64'hDEAD);
        drive(4'h3, 64'h66, 64'd0);
        W_stall = 1'b1;
        #1 chk("idle_wstall_mstall", ms[0], 1);
        tick();
        chk("idle_wstall_hold", we[0], 64'(10 * SC));
        W_stall = 1'b0;
        W_bubble = 1'b1;
        tick();
        chk("bubble_valid", wv[0], 0);
        chk("bubble_icode", wi[0], 1);
        chk("bubble_dstE", wde[0], 15);
        W_bubble = 1'b0;
        idle();
        reset_all();
        do_op(1, 4'h4, 64'(10 * SC), 64'hDEAD);
        drive(4'hB, 64'h18, 64'(10 * SC));
        #1 chk("pop_stall_c0", ms[1], 1);
        tick();
        chk("pop_stall_c1", ms[1], 1);
        chk("pop_early_c1", wi[1], 4);
        tick();
        chk("pop_stall_c2", ms[1], 0);
        chk("pop_early_c2", wi[1], 4);
        tick();
        chk("pop_icode", wi[1], 11);
        chk("pop_valM", wm[1], 64'hDEAD);
        chk("pop_valE", we[1], 64'h18);
        idle();
        reset_all();
        drive(4'h4, 64'(5 * SC), 64'h1234);
        tick();
        drive(4'h4, 64'(2048 * SC), 64'd1);
        tick();
        chk("adr_stat", ws[0], 8);
        chk("adr_halted", hl[0], 1);
        chk("adr_valM", wm[0], 0);
        drive(4'h4, 64'(5 * SC), 64'd7);
        tick();
        chk("halt_sticky", hl[0], 1);
        chk("halt_wr_stat", ws[0], 1);
        drive(4'h5, 64'(5 * SC), 64'd0);
        tick();
        chk("halt_no_write", wm[0], 64'h1234);
        drive(4'h5, 64'(2047 * SC), 64'd0);
        tick();
        chk("top_word_in_range", ws[0], 1);
        idle();
        reset_all();
        do_op(2, 4'h4, 64'(20 * SC), 64'h77);
        drive(4'hA, 64'(20 * SC), 64'd9);
        tick();
        tick();
        rst = 1'b1;
        idle();
        tick();
        rst = 1'b0;
        chk("abort_valid", wv[2], 0);
        chk("abort_stat", ws[2], 1);
        chk("abort_icode", wi[2], 1);
        chk("abort_halted", hl[2], 0);
        chk("abort_stall", ms[2], 0);
        repeat (4) tick();
        do_op(2, 4'h5, 64'(20 * SC), 64'd0);
        chk("abort_mem_kept", wm[2], 64'h77);
        reset_all();
        do_op(3, 4'h4, 64'(30 * SC), 64'hAB);
        drive(4'h5, 64'(30 * SC), 64'd0);
        #1 chk("lat2_stall", ms[3], 1);
        tick();
        W_stall = 1'b1;
        tick();
        chk("wstall_frz1", wi[3], 4);
        tick();
        chk("wstall_frz2", wi[3], 4);
        W_stall = 1'b0;
        #1 chk("wstall_release", ms[3], 0);
        tick();
        chk("wstall_done_icode", wi[3], 5);
        chk("wstall_done_valM", wm[3], 64'hAB);
        idle();
        reset_all();
        drive(4'h4, 64'(30 * SC), 64'h55);
        M_stat = 4'b0100;
        #1 chk("ins_no_stall", ms[3], 0);
        tick();
        chk("ins_stat", ws[3], 4);
        chk("ins_halted", hl[3], 1);
        idle();
        do_op(3, 4'h5, 64'(30 * SC), 64'd0);
        chk("ins_no_write", wm[3], 64'hAB);
        reset_all();
        drive(4'h5, 64'h13, 64'd0);
        tick();
        chk("addr_0x13_stat", ws[0], EXP13);
        idle();
        tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
